// File: rtl/jtag_debug_action_sched_pkg.sv
// rtl/jtag_debug_action_sched_pkg.sv - shared types, requester codes and jdo field layout
package jtag_debug_action_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] REQ_OCIMEM   = 2'd0;
  localparam logic [1:0] REQ_BREAK    = 2'd1;
  localparam logic [1:0] REQ_TRACEMEM = 2'd2;
  localparam int         NUM_REQ      = 3;

  // jdo layout: address from bit 2 upward, write data in [35:4], error-clear in bit 36
  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 2;
  localparam int JDO_WDATA_LSB = 4;
  localparam int JDO_WDATA_MSB = 35;
  localparam int JDO_CLR_BIT   = 36;

  // Slots keep only jdo[36:2], the span every field lives in
  localparam int JDO_BODY_W = JDO_CLR_BIT - JDO_ADDR_LSB + 1;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [JDO_BODY_W-1:0] body;
  } slot_t;

  function automatic logic [1:0] rr_next(input logic [1:0] code);
    return (code == REQ_TRACEMEM) ? REQ_OCIMEM : code + 2'd1;
  endfunction

endpackage

// File: rtl/jtag_debug_action_sched_if.sv
// rtl/jtag_debug_action_sched_if.sv - JTAG action requests, shared OCI port and monitor status
interface jtag_debug_action_sched_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_action_break_a;
  logic              take_action_tracemem_a;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_sel;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [2:0]        done;

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_action_break_a,
           take_action_tracemem_a, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel, MonDReg, monitor_ready,
           monitor_error, done
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_action_break_a,
           take_action_tracemem_a, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel, MonDReg, monitor_ready,
           monitor_error, done
  );
endinterface

// File: rtl/jtag_debug_action_sched_rr_arb3.sv
// rtl/jtag_debug_action_sched_rr_arb3.sv - three-way round-robin selector
module jtag_debug_rr_arb3
  import jtag_debug_action_sched_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic       o_valid,
  output logic [1:0] o_code
);
  logic [3:0] w_req;
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [1:0] w_c3;

  assign w_req = {1'b0, i_req};
  assign w_c1  = rr_next(i_last);
  assign w_c2  = rr_next(w_c1);
  assign w_c3  = rr_next(w_c2);

  // Scan the requesters starting just after the last-served one
  always_comb begin
    o_valid = 1'b0;
    o_code  = REQ_OCIMEM;
    if (w_req[w_c1]) begin
      o_valid = 1'b1;
      o_code  = w_c1;
    end else if (w_req[w_c2]) begin
      o_valid = 1'b1;
      o_code  = w_c2;
    end else if (w_req[w_c3]) begin
      o_valid = 1'b1;
      o_code  = w_c3;
    end
  end
endmodule

// File: rtl/jtag_debug_action_sched.sv
// rtl/jtag_debug_action_sched.sv - schedules JTAG debug actions onto one shared OCI port
module jtag_debug_action_sched
  import jtag_debug_action_sched_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 8
) (
  input logic                      clk,
  input logic                      reset,
  jtag_debug_action_sched_if.slave bus
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  slot_t [NUM_REQ-1:0]   r_slot;
  slot_t                 w_cur_slot;
  logic [JDO_BODY_W-1:0] w_body;
  logic [2:0]            w_pulse;
  logic [2:0]            w_pending;
  logic [2:0]            w_free;
  logic [2:0]            w_accept;
  logic                  w_overrun;
  logic                  w_arb_valid;
  logic [1:0]            w_arb_code;
  logic                  w_grant;
  logic                  w_issue;
  logic                  w_ack_hit;
  logic                  w_timeout;
  logic                  w_err_clr;
  logic [1:0]            r_last;
  logic [1:0]            r_gnt;
  logic [7:0]            r_tmo_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [1:0]            r_mem_sel;
  logic                  r_cur_clr;
  logic [31:0]           r_mon_dreg;
  logic                  r_mon_err;
  logic [2:0]            r_done;
  logic                  w_unused;

  assign w_pulse   = {bus.take_action_tracemem_a, bus.take_action_break_a,
                      bus.take_action_ocimem_a | bus.take_action_ocimem_b};
  assign w_pending = {r_slot[2].valid, r_slot[1].valid, r_slot[0].valid};
  // The slot being retired this cycle may be refilled without counting as an overrun
  assign w_free    = (r_state == S_DONE) ? (3'b001 << r_gnt) : 3'b000;
  assign w_accept  = w_pulse & (~w_pending | w_free);
  assign w_overrun = |(w_pulse & w_pending & ~w_free);
  assign w_body    = bus.jdo[JDO_CLR_BIT:JDO_ADDR_LSB];
  assign w_unused  = &{1'b0, bus.jdo[37], bus.jdo[1:0]};

  assign w_cur_slot = (r_gnt == REQ_TRACEMEM) ? r_slot[2] :
                      (r_gnt == REQ_BREAK)    ? r_slot[1] : r_slot[0];

  assign w_err_clr = w_ack_hit && r_mem_we && (r_mem_sel == REQ_OCIMEM) &&
                     (r_mem_addr == '0) && r_cur_clr;

  jtag_debug_rr_arb3 u_arb (
    .i_req   (w_pending),
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_code  (w_arb_code)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_ack_hit   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pending slots: capture on pulse, release when the owner finishes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_slot[i].valid <= 1'b1;
          r_slot[i].we    <= (i == 0) && bus.take_action_ocimem_b;
          r_slot[i].body  <= w_body;
        end else if (w_free[i]) begin
          r_slot[i].valid <= 1'b0;
        end
      end
    end
  end

  // Grant bookkeeping, port drive, timeout, read capture and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= REQ_TRACEMEM;
      r_gnt       <= REQ_OCIMEM;
      r_tmo_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= REQ_OCIMEM;
      r_cur_clr   <= 1'b0;
      r_mon_dreg  <= '0;
      r_mon_err   <= 1'b0;
      r_done      <= '0;
    end else begin
      r_done <= w_free;
      if (w_grant) begin
        r_gnt  <= w_arb_code;
        r_last <= w_arb_code;
      end
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_cur_slot.we;
        r_mem_addr  <= w_cur_slot.body[ADDR_W-1:0];
        r_mem_wdata <= w_cur_slot.body[JDO_WDATA_MSB-JDO_ADDR_LSB:JDO_WDATA_LSB-JDO_ADDR_LSB];
        r_mem_sel   <= r_gnt;
        r_cur_clr   <= w_cur_slot.body[JDO_CLR_BIT-JDO_ADDR_LSB];
      end
      if (r_state == S_WAIT) begin
        if (w_ack_hit || w_timeout) begin
          r_mem_req <= 1'b0;
          r_tmo_cnt <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
      end
      if (w_ack_hit && !r_mem_we) r_mon_dreg <= bus.mem_rdata;
      r_mon_err <= (r_mon_err & ~w_err_clr) | w_overrun | w_timeout;
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_sel       = r_mem_sel;
  assign bus.MonDReg       = r_mon_dreg;
  assign bus.monitor_error = r_mon_err;
  assign bus.monitor_ready = (r_state == S_IDLE) && (w_pending == 3'b000);
  assign bus.done          = r_done;
endmodule

// File: tb/tb_jtag_debug_action_sched.sv
// tb/tb_jtag_debug_action_sched.sv - directed self-checking bench for jtag_debug_action_sched
module tb_jtag_debug_action_sched;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  jtag_debug_action_sched_if #(.ADDR_W(8)) bus ();

  jtag_debug_action_sched #(.TIMEOUT(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // mask: [0] ocimem_a, [1] ocimem_b, [2] break_a, [3] tracemem_a
  task automatic pulse(input logic [3:0] mask, input logic [37:0] d);
    bus.jdo                    = d;
    bus.take_action_ocimem_a   = mask[0];
    bus.take_action_ocimem_b   = mask[1];
    bus.take_action_break_a    = mask[2];
    bus.take_action_tracemem_a = mask[3];
    tick();
    bus.take_action_ocimem_a   = 1'b0;
    bus.take_action_ocimem_b   = 1'b0;
    bus.take_action_break_a    = 1'b0;
    bus.take_action_tracemem_a = 1'b0;
    bus.jdo                    = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Acknowledges every request immediately and records what was seen
  task automatic drain(input int cycles, input logic [31:0] rdata,
                       output int nreq, output int ndone,
                       output logic [7:0] sel_seq, output logic [11:0] done_seq,
                       output logic [7:0] first_addr);
    nreq = 0; ndone = 0; sel_seq = '0; done_seq = '0; first_addr = '0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.mem_req && !bus.mem_ack) begin
        if (nreq < 4) sel_seq[nreq*2 +: 2] = bus.mem_sel;
        if (nreq == 0) first_addr = bus.mem_addr;
        nreq++;
      end
      if (bus.done != 3'b000) begin
        if (ndone < 4) done_seq[ndone*3 +: 3] = bus.done;
        ndone++;
      end
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = rdata;
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b exp 0", bus.mem_req); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b exp 0", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_mem_addr: got %h exp 00", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h exp 0", bus.mem_wdata); end
    vectors++; if (bus.mem_sel !== 2'd0) begin miscompares++; $display("FAIL reset_mem_sel: got %0d exp 0", bus.mem_sel); end
    vectors++; if (bus.MonDReg !== 32'h0) begin miscompares++; $display("FAIL reset_mondreg: got %h exp 0", bus.MonDReg); end
    vectors++; if (bus.monitor_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b exp 0", bus.monitor_error); end
    vectors++; if (bus.done !== 3'b000) begin miscompares++; $display("FAIL reset_done: got %b exp 000", bus.done); end
    vectors++; if (bus.monitor_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b exp 1", bus.monitor_ready); end
  endtask

  task automatic test_read();
    bit ok;
    apply_reset();
    pulse(4'b0001, 38'h14);
    vectors++; if (bus.monitor_ready !== 1'b0) begin miscompares++; $display("FAIL read_ready_pending: got %b exp 0", bus.monitor_ready); end
    wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL read_req_timeout: got %b exp 1", ok); end
    vectors++; if (bus.mem_addr !== 8'h05) begin miscompares++; $display("FAIL read_addr: got %h exp 05", bus.mem_addr); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL read_we: got %b exp 0", bus.mem_we); end
    vectors++; if (bus.mem_sel !== 2'd0) begin miscompares++; $display("FAIL read_sel: got %0d exp 0", bus.mem_sel); end
    tick();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL read_req_drop: got %b exp 0", bus.mem_req); end
    vectors++; if (bus.MonDReg !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_mondreg: got %h exp deadbeef", bus.MonDReg); end
    tick();
    vectors++; if (bus.done !== 3'b001) begin miscompares++; $display("FAIL read_done: got %b exp 001", bus.done); end
    vectors++; if (bus.monitor_ready !== 1'b1) begin miscompares++; $display("FAIL read_ready_back: got %b exp 1", bus.monitor_ready); end
    tick();
    vectors++; if (bus.done !== 3'b000) begin miscompares++; $display("FAIL read_done_pulse: got %b exp 000", bus.done); end
  endtask

  task automatic test_latency();
    int lat;
    apply_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1234;
    pulse(4'b0001, 38'h14);
    lat = 0;
    while (bus.done === 3'b000 && lat < 20) begin
      tick();
      lat++;
    end
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL min_latency: got %0d exp 4", lat); end
    vectors++; if (bus.MonDReg !== 32'h0000_1234) begin miscompares++; $display("FAIL latency_mondreg: got %h exp 00001234", bus.MonDReg); end
    vectors++; if (bus.monitor_error !== 1'b0) begin miscompares++; $display("FAIL latency_error: got %b exp 0", bus.monitor_error); end
  endtask

  task automatic test_round_robin();
    int nreq, ndone;
    logic [7:0]  sel_seq;
    logic [11:0] done_seq;
    logic [7:0]  addr;
    apply_reset();
    pulse(4'b1101, 38'h28);
    drain(30, 32'h0, nreq, ndone, sel_seq, done_seq, addr);
    vectors++; if (nreq !== 3) begin miscompares++; $display("FAIL rr_nreq: got %0d exp 3", nreq); end
    vectors++; if (ndone !== 3) begin miscompares++; $display("FAIL rr_ndone: got %0d exp 3", ndone); end
    vectors++; if (sel_seq[5:0] !== 6'b10_01_00) begin miscompares++; $display("FAIL rr_sel_order: got %b exp 100100", sel_seq[5:0]); end
    vectors++; if (done_seq[8:0] !== 9'b100_010_001) begin miscompares++; $display("FAIL rr_done_order: got %b exp 100010001", done_seq[8:0]); end
    vectors++; if (addr !== 8'h0A) begin miscompares++; $display("FAIL rr_addr: got %h exp 0a", addr); end
  endtask

  task automatic test_timeout();
    int nreq, ndone, cnt;
    logic [7:0]  sel_seq;
    logic [11:0] done_seq;
    logic [7:0]  addr;
    bit ok;
    apply_reset();
    pulse(4'b0001, 38'h14);
    drain(10, 32'hCAFEF00D, nreq, ndone, sel_seq, done_seq, addr);
    pulse(4'b0001, 38'h14);
    wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL tmo_req_timeout: got %b exp 1", ok); end
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (!bus.mem_req) break;
      cnt++;
    end
    vectors++; if (cnt !== 8) begin miscompares++; $display("FAIL tmo_wait_cycles: got %0d exp 8", cnt); end
    vectors++; if (bus.monitor_error !== 1'b1) begin miscompares++; $display("FAIL tmo_error: got %b exp 1", bus.monitor_error); end
    tick();
    vectors++; if (bus.done !== 3'b001) begin miscompares++; $display("FAIL tmo_done: got %b exp 001", bus.done); end
    vectors++; if (bus.MonDReg !== 32'hCAFEF00D) begin miscompares++; $display("FAIL tmo_mondreg: got %h exp cafef00d", bus.MonDReg); end
  endtask

  task automatic test_overrun();
    int nreq, ndone;
    logic [7:0]  sel_seq;
    logic [11:0] done_seq;
    logic [7:0]  addr;
    apply_reset();
    pulse(4'b0100, 38'h44);
    pulse(4'b0100, 38'h220);
    vectors++; if (bus.monitor_error !== 1'b1) begin miscompares++; $display("FAIL ovr_error: got %b exp 1", bus.monitor_error); end
    drain(25, 32'h0, nreq, ndone, sel_seq, done_seq, addr);
    vectors++; if (nreq !== 1) begin miscompares++; $display("FAIL ovr_nreq: got %0d exp 1", nreq); end
    vectors++; if (ndone !== 1) begin miscompares++; $display("FAIL ovr_ndone: got %0d exp 1", ndone); end
    vectors++; if (addr !== 8'h11) begin miscompares++; $display("FAIL ovr_first_payload: got %h exp 11", addr); end
    vectors++; if (done_seq[2:0] !== 3'b010) begin miscompares++; $display("FAIL ovr_done_bit: got %b exp 010", done_seq[2:0]); end
  endtask

  task automatic test_error_clear();
    int nreq, ndone;
    logic [7:0]  sel_seq;
    logic [11:0] done_seq;
    logic [7:0]  addr;
    bit ok;
    apply_reset();
    pulse(4'b1000, 38'h0);
    pulse(4'b1000, 38'h0);
    drain(15, 32'h0, nreq, ndone, sel_seq, done_seq, addr);
    vectors++; if (bus.monitor_error !== 1'b1) begin miscompares++; $display("FAIL clr_error_set: got %b exp 1", bus.monitor_error); end
    pulse(4'b0010, 38'h10_0000_0010);
    drain(15, 32'h0, nreq, ndone, sel_seq, done_seq, addr);
    vectors++; if (addr !== 8'h04) begin miscompares++; $display("FAIL clr_nonzero_addr: got %h exp 04", addr); end
    vectors++; if (bus.monitor_error !== 1'b1) begin miscompares++; $display("FAIL clr_wrong_addr_kept: got %b exp 1", bus.monitor_error); end
    pulse(4'b0011, 38'h11_2345_6400);
    wait_req(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL clr_req_timeout: got %b exp 1", ok); end
    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL clr_a_and_b_is_write: got %b exp 1", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 8'h00) begin miscompares++; $display("FAIL clr_addr: got %h exp 00", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 32'h12345640) begin miscompares++; $display("FAIL clr_wdata: got %h exp 12345640", bus.mem_wdata); end
    vectors++; if (bus.monitor_error !== 1'b1) begin miscompares++; $display("FAIL clr_before_ack: got %b exp 1", bus.monitor_error); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick();
    vectors++; if (bus.done !== 3'b001) begin miscompares++; $display("FAIL clr_done: got %b exp 001", bus.done); end
    vectors++; if (bus.monitor_error !== 1'b0) begin miscompares++; $display("FAIL clr_error_cleared: got %b exp 0", bus.monitor_error); end
    vectors++; if (bus.MonDReg !== 32'h0) begin miscompares++; $display("FAIL clr_write_no_capture: got %h exp 0", bus.MonDReg); end
  endtask

  task automatic test_reset_in_wait();
    int nreq, ndone;
    logic [7:0]  sel_seq;
    logic [11:0] done_seq;
    logic [7:0]  addr;
    logic [2:0]  seen;
    bit ok;
    apply_reset();
    pulse(4'b0001, 38'h14);
    drain(10, 32'h0BADF00D, nreq, ndone, sel_seq, done_seq, addr);
    pulse(4'b1000, 38'h3C);
    wait_req(ok);
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_wait_req: got %b exp 0", bus.mem_req); end
    vectors++; if (bus.mem_sel !== 2'd0) begin miscompares++; $display("FAIL rst_wait_sel: got %0d exp 0", bus.mem_sel); end
    vectors++; if (bus.mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_wait_addr: got %h exp 00", bus.mem_addr); end
    vectors++; if (bus.MonDReg !== 32'h0) begin miscompares++; $display("FAIL rst_wait_mondreg: got %h exp 0", bus.MonDReg); end
    vectors++; if (bus.monitor_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wait_ready: got %b exp 1", bus.monitor_ready); end
    tick();
    tick();
    reset = 1'b0;
    seen = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      seen = seen | bus.done;
    end
    vectors++; if (seen !== 3'b000) begin miscompares++; $display("FAIL rst_wait_no_done: got %b exp 000", seen); end
    pulse(4'b0001, 38'h14);
    drain(10, 32'h13579BDF, nreq, ndone, sel_seq, done_seq, addr);
    vectors++; if (bus.MonDReg !== 32'h13579BDF) begin miscompares++; $display("FAIL rst_after_mondreg: got %h exp 13579bdf", bus.MonDReg); end
    vectors++; if (done_seq[2:0] !== 3'b001) begin miscompares++; $display("FAIL rst_after_done: got %b exp 001", done_seq[2:0]); end
  endtask

  initial begin
    vectors                    = 0;
    miscompares                = 0;
    reset                      = 1'b1;
    bus.jdo                    = '0;
    bus.take_action_ocimem_a   = 1'b0;
    bus.take_action_ocimem_b   = 1'b0;
    bus.take_action_break_a    = 1'b0;
    bus.take_action_tracemem_a = 1'b0;
    bus.mem_ack                = 1'b0;
    bus.mem_rdata              = '0;
    test_reset();
    test_read();
    test_latency();
    test_round_robin();
    test_timeout();
    test_overrun();
    test_error_clear();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_debug_action_sched.md
JTAG_DEBUG_ACTION_SCHED -- requirements
Module: jtag_debug_action_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for mem_ack before aborting an access; legal range 2..255.
REQ-002 Parameter ADDR_W, default 8: width of the shared OCI port address.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 jdo  in  38  JTAG payload, valid in the cycle of any take_action pulse.
REQ-006 take_action_ocimem_a / _b  in  1 each  OCI memory read / write request pulse.
REQ-007 take_action_break_a  in  1  break-register access request pulse.
REQ-008 take_action_tracemem_a  in  1  trace-memory read request pulse.
REQ-009 mem_req  out  1  shared-port request, held until ack or timeout.
REQ-010 mem_we  out  1  write qualifier.
REQ-011 mem_addr  out  ADDR_W  address (jdo[ADDR_W+1:2]).
REQ-012 mem_wdata  out  32  write data (jdo[35:4]).
REQ-013 mem_sel  out  2  owning requester: 0 ocimem, 1 break, 2 tracemem.
REQ-014 mem_ack  in  1  one-cycle completion.
REQ-015 mem_rdata  in  32  read data, valid with mem_ack.
REQ-016 MonDReg  out  32  last captured read data.
REQ-017 monitor_ready  out  1  high when no request is pending or active.
REQ-018 monitor_error  out  1  sticky timeout/overrun flag.
REQ-019 done  out  3  one-cycle completion pulse per requester (bit = mem_sel code).

Function
REQ-020 Each requester SHALL own a one-entry pending slot capturing the jdo fields and the write bit (the write bit is set by _ocimem_b) on its pulse.
REQ-021 Simultaneous _ocimem_a and _ocimem_b SHALL be treated as a write.
REQ-022 A pulse arriving while that requester's slot is already pending SHALL be dropped and SHALL set monitor_error; the existing slot SHALL NOT change.
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-024 IDLE -> ISSUE SHALL occur when any slot is pending, with a round-robin grant starting after the last-served requester; after reset the priority order is ocimem, break, tracemem.
REQ-025 In ISSUE, mem_req SHALL assert one cycle after the grant, with addr, we, wdata and sel stable, and the FSM SHALL go to WAIT.
REQ-026 In WAIT, mem_req SHALL stay high; when mem_ack is seen the FSM SHALL go to DONE, and on a read MonDReg SHALL load mem_rdata.
REQ-027 In WAIT the timeout counter SHALL increment every cycle; if it reaches TIMEOUT-1 without an ack, mem_req SHALL drop, monitor_error SHALL set, MonDReg SHALL NOT change, and the FSM SHALL go to DONE.
REQ-028 In DONE, the granted requester's done bit SHALL pulse, its slot SHALL clear, and the FSM SHALL return to IDLE; the minimum latency from pulse to done is 4 cycles.
REQ-029 A pulse for the requester that is in DONE in the same cycle SHALL be accepted into the freed slot; this is not an overrun.
REQ-030 An ack arriving outside WAIT SHALL be ignored.
REQ-031 monitor_error SHALL clear only when an ocimem write to address 0 completes with jdo[36]=1.
REQ-032 monitor_ready SHALL equal (state==IDLE) and no slot pending.

Reset
REQ-033 Reset SHALL drive: state IDLE, all slots empty, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_sel 0, MonDReg 0, monitor_error 0, done 0, timeout counter 0, round-robin pointer to tracemem (so ocimem wins first).
REQ-034 Reset asserted mid-transaction SHALL abort it with no done pulse.

Structure
REQ-035 A shared package SHALL hold the state enum, the requester codes (OCIMEM=0, BREAK=1, TRACEMEM=2) and the jdo field bit positions.
REQ-036 The round-robin selector SHALL be one sub-module, jtag_debug_rr_arb3.

Verification
REQ-037 Bench SHALL cover: _ocimem_a with jdo addr 0x05, ack on the 3rd WAIT cycle with rdata 0xDEADBEEF -> MonDReg=0xDEADBEEF, done[0] pulse, monitor_ready returns high.
REQ-038 Bench SHALL cover: break, tracemem and ocimem pulses in the same cycle -> served in order ocimem, break, tracemem; three done pulses, one per requester.
REQ-039 Bench SHALL cover: no ack with TIMEOUT=8 -> mem_req drops after 8 WAIT cycles, monitor_error=1, done pulses, MonDReg unchanged.
REQ-040 Bench SHALL cover: a second _break_a while break is pending -> monitor_error=1, first payload served, only one done[1].
REQ-041 Bench SHALL cover: reset asserted during WAIT -> all outputs at reset values immediately, no done pulse; a later request completes normally.
REQ-042 Bench SHALL cover: ocimem write to addr 0 with jdo[36]=1 while monitor_error=1 -> monitor_error=0 after done.
